// File: rtl/harvard_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// master drives the stage inputs; slave is the decode stage.
interface harvard_decode_stage_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [PC_W-1:0] out_pc;
  logic [1:0]      out_class;
  logic            out_mem_active;
  logic            out_mem_write;
  logic            out_reg_active;
  logic [4:0]      out_reg_dst;
  logic [XLEN-1:0] out_imm;
  logic            out_branch;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_class,
    input  out_mem_active, out_mem_write, out_reg_active,
    input  out_reg_dst, out_imm, out_branch, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_class,
    output out_mem_active, out_mem_write, out_reg_active,
    output out_reg_dst, out_imm, out_branch, out_illegal
  );
endinterface

// File: rtl/harvard_decode_stage.sv
// MIPS decode stage: R/I/J classification with registered
// control, output register plus optional skid entry.
module harvard_decode_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = 32,
  parameter int SKID = 1
) (
  input logic                  clk,
  input logic                  reset,
  input logic                  flush,
  harvard_decode_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [1:0]      cls;
    logic            ma;
    logic            mw;
    logic            ra;
    logic [4:0]      dst;
    logic [XLEN-1:0] imm;
    logic            br;
    logic            ill;
  } rec_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  logic [31:0] ins;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        wr;
  rec_t        dec;

  assign ins = bus.in_instr;
  assign op  = ins[31:26];
  assign fn  = ins[5:0];

  always_comb begin
    dec     = '0;
    wr      = 1'b0;
    dec.pc  = bus.in_pc;
    dec.cls = 2'd1;
    dec.dst = ins[20:16];
    dec.imm = XLEN'($signed(ins[15:0]));
    unique case (op)
      6'h00: begin
        dec.cls = 2'd0;
        dec.dst = ins[15:11];
        unique case (fn)
          6'h00, 6'h02, 6'h03, 6'h21, 6'h23,
          6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B: wr = 1'b1;
          6'h08: dec.br = 1'b1;
          6'h09: begin
            dec.br = 1'b1;
            wr     = 1'b1;
          end
          default: dec.ill = 1'b1;
        endcase
      end
      6'h02, 6'h03: begin
        dec.cls = 2'd2;
        dec.br  = 1'b1;
        dec.imm = XLEN'(ins[25:0]);
        if (op == 6'h03) begin
          wr      = 1'b1;
          dec.dst = 5'd31;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: dec.br = 1'b1;
      6'h09, 6'h0A, 6'h0B: wr = 1'b1;
      6'h0C, 6'h0D, 6'h0E: begin
        wr      = 1'b1;
        dec.imm = XLEN'(ins[15:0]);
      end
      6'h0F: begin
        wr      = 1'b1;
        dec.imm = XLEN'($signed({ins[15:0], 16'h0}));
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.ma = 1'b1;
        wr     = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.ma = 1'b1;
        dec.mw = 1'b1;
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal records still flow, but must not cause side effects.
    if (dec.ill) begin
      dec.cls = 2'd1;
      dec.ma  = 1'b0;
      dec.mw  = 1'b0;
      dec.br  = 1'b0;
      wr      = 1'b0;
    end
    dec.ra = wr & (dec.dst != 5'd0);
  end

  state_e state_q, state_d;
  rec_t   out_q, out_d;
  rec_t   skid_q, skid_d;
  logic   rdy_q;
  logic   acc;
  logic   xfer;

  assign acc  = bus.in_valid & bus.in_ready;
  assign xfer = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          out_d   = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && xfer) begin
          out_d = dec;
        end else if (acc) begin
          skid_d  = dec;
          state_d = TWO;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      rdy_q   <= (state_d != TWO);
    end
  end

  // Without a skid entry the stage never reaches TWO, so rdy_q only gates reset.
  assign bus.in_ready = (SKID != 0) ? rdy_q
                      : rdy_q & ((state_q != ONE) | bus.out_ready);

  assign bus.out_valid      = (state_q != EMPTY);
  assign bus.out_pc         = out_q.pc;
  assign bus.out_class      = out_q.cls;
  assign bus.out_mem_active = out_q.ma;
  assign bus.out_mem_write  = out_q.mw;
  assign bus.out_reg_active = out_q.ra;
  assign bus.out_reg_dst    = out_q.dst;
  assign bus.out_imm        = out_q.imm;
  assign bus.out_branch     = out_q.br;
  assign bus.out_illegal    = out_q.ill;
endmodule

// File: tb/tb_harvard_decode_stage.sv
// Randomized and directed bench for harvard_decode_stage
// against a queue-based reference model.
module tb_harvard_decode_stage;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;

  always #5 clk = ~clk;

  harvard_decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();

  harvard_decode_stage #(
    .XLEN(32),
    .PC_W(32),
    .SKID(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .flush(flush),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  cls;
    logic        ma;
    logic        mw;
    logic        ra;
    logic [4:0]  dst;
    logic        dchk;
    logic [31:0] imm;
    logic        ichk;
    logic        br;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic exp_t ref_dec(input logic [31:0] i,
                                   input logic [31:0] pc);
    exp_t e;
    logic wr;
    logic [5:0] op, fn;
    logic [31:0] sx, zx;
    op = i[31:26];
    fn = i[5:0];
    sx = {{16{i[15]}}, i[15:0]};
    zx = {16'h0, i[15:0]};
    e = '{default: '0};
    e.pc = pc;
    e.cls = 2'd1;
    e.dst = i[20:16];
    e.imm = sx;
    e.ichk = 1'b1;
    wr = 1'b0;
    if (op == 6'h00) begin
      e.cls = 2'd0;
      e.ichk = 1'b0;
      e.dst = i[15:11];
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h21, 6'h23, 6'h24,
                     6'h25, 6'h26, 6'h2A, 6'h2B}) wr = 1'b1;
      else if (fn == 6'h08) e.br = 1'b1;
      else if (fn == 6'h09) begin e.br = 1'b1; wr = 1'b1; end
      else e.ill = 1'b1;
    end else if (op inside {6'h02, 6'h03}) begin
      e.cls = 2'd2;
      e.br = 1'b1;
      e.imm = {6'h0, i[25:0]};
      if (op == 6'h03) begin wr = 1'b1; e.dst = 5'd31; end
    end else if (op inside {[6'h04:6'h07]}) begin
      e.br = 1'b1;
    end else if (op inside {6'h09, 6'h0A, 6'h0B}) begin
      wr = 1'b1;
    end else if (op inside {[6'h0C:6'h0E]}) begin
      wr = 1'b1;
      e.imm = zx;
    end else if (op == 6'h0F) begin
      wr = 1'b1;
      e.imm = {i[15:0], 16'h0};
    end else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      e.ma = 1'b1;
      wr = 1'b1;
    end else if (op inside {6'h28, 6'h29, 6'h2B}) begin
      e.ma = 1'b1;
      e.mw = 1'b1;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) begin
      e.cls = 2'd1;
      e.ichk = 1'b0;
      e.ma = 1'b0;
      e.mw = 1'b0;
      e.br = 1'b0;
      wr = 1'b0;
    end
    e.dchk = wr;
    e.ra = wr && (e.dst != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [0:23] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04,
      6'h05, 6'h06, 6'h07, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
      6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
      6'h3F};
    logic [5:0] fns [0:12] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
      6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h2B, 6'h01};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) != 0) begin
      r[31:26] = ops[$urandom_range(0, 23)];
      if (r[31:26] == 6'h00 && $urandom_range(0, 4) != 0)
        r[5:0] = fns[$urandom_range(0, 12)];
    end
    if ($urandom_range(0, 7) == 0) r[20:11] = '0;
    return r;
  endfunction

  task automatic check_model();
    check("out_valid", bus.out_valid, q.size() != 0);
    check("in_ready", bus.in_ready, q.size() < 2);
    if (q.size() != 0) begin
      check("pc", bus.out_pc, q[0].pc);
      check("class", bus.out_class, q[0].cls);
      check("mem_active", bus.out_mem_active, q[0].ma);
      check("mem_write", bus.out_mem_write, q[0].mw);
      check("reg_active", bus.out_reg_active, q[0].ra);
      check("branch", bus.out_branch, q[0].br);
      check("illegal", bus.out_illegal, q[0].ill);
      if (q[0].dchk) check("reg_dst", bus.out_reg_dst, q[0].dst);
      if (q[0].ichk) check("imm", bus.out_imm, q[0].imm);
    end
  endtask

  // Drive one cycle at the falling edge, advance the model, check after.
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic rdy,
                      input logic fl, output logic acc);
    logic xf;
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = pc;
    bus.out_ready = rdy;
    flush         = fl;
    #1;
    acc = v & bus.in_ready;
    xf  = bus.out_valid & rdy;
    if (fl) begin
      q.delete();
    end else begin
      if (xf && q.size() != 0) void'(q.pop_front());
      if (acc) q.push_back(ref_dec(ins, pc));
    end
    @(negedge clk);
    check_model();
  endtask

  logic a;
  logic [31:0] pc;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_pc", bus.out_pc, 0);
    check("rst_out_imm", bus.out_imm, 0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", bus.in_ready, 0);
    @(negedge clk);
    check_model();

    step(1, 32'h8D280004, 32'h100, 1, 0, a);
    check("lw_class", bus.out_class, 1);
    check("lw_mem_active", bus.out_mem_active, 1);
    check("lw_mem_write", bus.out_mem_write, 0);
    check("lw_reg_active", bus.out_reg_active, 1);
    check("lw_reg_dst", bus.out_reg_dst, 8);
    check("lw_imm", bus.out_imm, 32'h4);
    step(1, 32'h24638000, 32'h104, 1, 0, a);
    check("addiu_imm", bus.out_imm, 32'hFFFF8000);
    step(1, 32'h30638000, 32'h108, 1, 0, a);
    check("andi_imm", bus.out_imm, 32'h00008000);
    check("andi_reg_dst", bus.out_reg_dst, 3);
    step(1, 32'h0C000010, 32'h10C, 1, 0, a);
    check("jal_class", bus.out_class, 2);
    check("jal_branch", bus.out_branch, 1);
    check("jal_reg_active", bus.out_reg_active, 1);
    check("jal_reg_dst", bus.out_reg_dst, 31);
    check("jal_imm", bus.out_imm, 32'h10);
    step(1, 32'h00000021, 32'h110, 1, 0, a);
    check("addu0_reg_active", bus.out_reg_active, 0);
    step(1, 32'hFC000000, 32'h114, 1, 0, a);
    check("ill_op_illegal", bus.out_illegal, 1);
    check("ill_op_ctrl", {bus.out_mem_active, bus.out_mem_write,
                          bus.out_reg_active, bus.out_branch}, 0);
    step(1, 32'h0000003F, 32'h118, 1, 0, a);
    check("ill_fn_illegal", bus.out_illegal, 1);
    step(0, 0, 0, 1, 0, a);

    // back-pressure: third instruction waits until space frees up
    step(1, 32'h8D280004, 32'h0, 0, 0, a);
    step(1, 32'h8D280004, 32'h4, 0, 0, a);
    check("bp_in_ready_low", bus.in_ready, 0);
    step(1, 32'h8D280004, 32'h8, 0, 0, a);
    check("bp_hold_pc", bus.out_pc, 32'h0);
    step(1, 32'h8D280004, 32'h8, 1, 0, a);
    check("bp_drain0", bus.out_pc, 32'h4);
    step(1, 32'h8D280004, 32'h8, 1, 0, a);
    check("bp_accept8", a, 1);
    check("bp_drain1", bus.out_pc, 32'h8);
    step(0, 0, 0, 1, 0, a);
    check("bp_empty", bus.out_valid, 0);

    // flush with two buffered, then with one buffered plus an accept
    step(1, 32'h24630001, 32'h20, 0, 0, a);
    step(1, 32'h24630002, 32'h24, 0, 0, a);
    step(1, 32'h24630003, 32'h28, 0, 1, a);
    check("flush2_valid", bus.out_valid, 0);
    step(1, 32'h24630004, 32'h2C, 0, 0, a);
    step(1, 32'h24630005, 32'h30, 0, 1, a);
    check("flush1_valid", bus.out_valid, 0);
    step(0, 0, 0, 1, 0, a);
    step(0, 0, 0, 1, 0, a);

    // asynchronous reset with records in flight
    step(1, 32'h8D280004, 32'h40, 0, 0, a);
    step(1, 32'h8D280004, 32'h44, 0, 0, a);
    reset = 1'b1;
    #1;
    check("arst_valid", bus.out_valid, 0);
    check("arst_in_ready", bus.in_ready, 0);
    q.delete();
    @(negedge clk);
    check("arst_hold_ready", bus.in_ready, 0);
    reset = 1'b0;
    step(0, 0, 0, 1, 0, a);

    pc = 32'h1000;
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), pc,
           $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0, a);
      if (a) pc = pc + 32'd4;
    end
    for (int n = 0; n < 4; n++) step(0, 0, 0, 1, 0, a);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
